serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor. Successor to the single-bit combinational full adder.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB first, through one DIGIT-wide ripple slice and a registered carry.
- Provides add/sub mode, carry-in/borrow-in, carry-out and signed overflow.
- Sits in the arithmetic datapath wherever area matters more than latency. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH; N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- sub  input  1  0 = add, 1 = subtract, captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: s/cout/ovf newly valid
- s  output  WIDTH  result
- cout  output  1  raw carry out of MSB
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Arithmetic:
  - add: {cout,s} = a + b + cin.
  - sub: {cout,s} = a + ~b + ~cin, i.e. s = a − b − cin mod 2^WIDTH; cout=1 means no borrow.
  - ovf = carry into MSB XOR carry out of MSB.
- Operand, carry and mode capture: on accept, store a and (sub ? ~b : b) into shift registers; initial carry = sub ? ~cin : cin.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → accept, digit counter=0, go to RUN.
  - RUN: busy=1. Each clock adds the low DIGIT bits of both shift registers plus the stored carry. The digit sum shifts into the result shift register from the MSB end, the operands shift right by DIGIT, and the carry updates. The last digit also records the carry into the MSB for ovf.
  - End of RUN: after the N-th digit (counter = N−1), load s/cout/ovf output registers and go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE (go to RUN); otherwise go to IDLE.
- Latency: start sampled at edge E0 → busy high for the N cycles after E0; done high in the cycle after edge E0+N.
- Back-to-back throughput: one result per N+1 cycles.
- start while busy=1: ignored, with no effect on the operation in flight.
- Output hold: s/cout/ovf change only at the DONE load and otherwise hold their last value, including during a subsequent RUN.
- Inputs a/b/cin/sub: may change freely after the accept edge.
- Reset (rst=1 at any edge, including mid-RUN or in DONE):
  - state → IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal registers cleared.
  - In-flight operation is abandoned and produces no done.
  - start is ignored in any cycle where rst=1.
- DIGIT = WIDTH: N=1; done follows start by one edge.

Test Plan:
- WIDTH=8, DIGIT=1, add 0x3C + 0x5A, cin=0 → busy 8 cycles, done in cycle 9; s=0x96, cout=0, ovf=1.
- WIDTH=8, DIGIT=1, sub 0x10 − 0x20, cin=0 → s=0xF0, cout=0, ovf=0. Then sub 0x80 − 0x01, cin=0 → s=0x7F, cout=1, ovf=1.
- WIDTH=8, add 0xFF + 0x01, cin=1 → s=0x01, cout=1, ovf=0. Pulse start=1 with different operands mid-RUN → ignored, same result, single done pulse.
- WIDTH=8, start 0x3C + 0x5A, assert rst on the 3rd RUN cycle → busy=0, s=0, no done. Next start 0x01 + 0x02 → s=0x03 after 8 cycles.
- WIDTH=16, DIGIT=4: add 0x7FFF + 0x0001 → done after 4 busy cycles, s=0x8000, cout=0, ovf=1. Hold start=1 in the DONE cycle with sub 0x0000 − 0x0001 → accepted immediately, s=0xFFFF, cout=0, ovf=0.
- WIDTH=8, DIGIT=8 → done one cycle after start. Random regression over all DIGIT divisors of WIDTH vs. a reference model.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor.
// WIDTH-bit operands are processed DIGIT bits per clock, LSB first, through a
// single DIGIT-wide ripple slice and a registered carry. A start/busy/done
// handshake frames each operation; results are held until the next DONE load.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [WIDTH-1:0] res_sh;

  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] res_next;

  // One ripple slice: low digit of each operand plus the stored carry.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    dsum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of the slice, recovered from its sum bit.
    c_msb = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    last  = (cnt == CW'(N - 1));
  end

  // The new digit enters the result register from the MSB end.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign res_next = {dsum[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Control FSM and datapath registers; rst takes priority over start.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      res_sh <= '0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + ~cin; fold the inversions in at capture.
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub ? ~cin : cin;
            cnt    <= '0;
            res_sh <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= dsum[DIGIT];
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            s     <= res_next;
            cout  <= dsum[DIGIT];
            ovf   <= c_msb ^ dsum[DIGIT];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: five configurations side by side,
// directed scenarios plus randomized regression against an arithmetic model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  start_v;
  logic [15:0] a_in, b_in;
  logic        cin_in, sub_in;
  logic [4:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  s0, s1, s2, s3;
  logic [15:0] s4;

  int checks   = 0;
  int failures = 0;

  int w_t[5] = '{8, 8, 8, 8, 16};
  int n_t[5] = '{8, 4, 2, 1, 4};
  logic [15:0] prev_s[5];

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_v[0]), .done(done_v[0]), .s(s0),
    .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_v[1]), .done(done_v[1]), .s(s1),
    .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_v[2]), .done(done_v[2]), .s(s2),
    .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_v[3]), .done(done_v[3]), .s(s3),
    .cout(cout_v[3]), .ovf(ovf_v[3]));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .a(a_in), .b(b_in),
    .cin(cin_in), .sub(sub_in), .busy(busy_v[4]), .done(done_v[4]), .s(s4),
    .cout(cout_v[4]), .ovf(ovf_v[4]));

  function automatic logic [15:0] get_s(input int idx);
    case (idx)
      0: return {8'h00, s0};
      1: return {8'h00, s1};
      2: return {8'h00, s2};
      3: return {8'h00, s3};
      default: return s4;
    endcase
  endfunction

  // Reference: plain integer arithmetic. Subtraction is a - b - cin, with
  // cout meaning "no borrow"; overflow is the true signed result leaving range.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, input logic sb,
                                output logic [15:0] es, output logic ec, output logic eo);
    longint m  = longint'(1) << w;
    longint ua = longint'(a) & (m - 1);
    longint ub = longint'(b) & (m - 1);
    longint c  = longint'(ci);
    longint full, sa, sbv, r;
    full = sb ? (ua - ub - c) : (ua + ub + c);
    es   = 16'(full & (m - 1));
    ec   = sb ? (full >= 0) : (full >= m);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sbv  = (ub >= m / 2) ? ub - m : ub;
    r    = sb ? (sa - sbv - c) : (sa + sbv + c);
    eo   = (r < -(m / 2)) || (r >= m / 2);
  endfunction

  // Issues one operation on instance idx starting from IDLE or DONE and
  // returns one time unit after the DONE-entry edge (done expected high).
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input bit inject);
    logic [15:0] es;
    logic        ec, eo;
    bit          bad;
    logic [15:0] bad_s;
    logic        bad_busy, bad_done;
    int          n = n_t[idx];
    model(w_t[idx], a, b, ci, sb, es, ec, eo);
    a_in = a; b_in = b; cin_in = ci; sub_in = sb;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    bad = 0; bad_s = '0; bad_busy = 1'b0; bad_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!bad && (busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0 || get_s(idx) !== prev_s[idx])) begin
        bad = 1; bad_s = get_s(idx); bad_busy = busy_v[idx]; bad_done = done_v[idx];
      end
      // Operands may change freely after accept; a start while busy is ignored.
      a_in = 16'($urandom); b_in = 16'($urandom);
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      start_v[idx] = (inject && k == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start_v[idx] = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL run_phase u%0d: busy=%b done=%b s=%h, required busy=1 done=0 s=%h",
               idx, bad_busy, bad_done, bad_s, prev_s[idx]);
    end
    checks++;
    if (done_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse u%0d: done=%b busy=%b, required done=1 busy=0",
               idx, done_v[idx], busy_v[idx]);
    end
    checks++;
    if (get_s(idx) !== es || cout_v[idx] !== ec || ovf_v[idx] !== eo) begin
      failures++;
      $display("FAIL result u%0d a=%h b=%h cin=%b sub=%b: s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
               idx, a, b, ci, sb, get_s(idx), cout_v[idx], ovf_v[idx], es, ec, eo);
    end
    prev_s[idx] = es;
  endtask

  task automatic check_idle(input int idx);
    @(posedge clk); #1;
    checks++;
    if (busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b0 || get_s(idx) !== prev_s[idx]) begin
      failures++;
      $display("FAIL idle_after_done u%0d: busy=%b done=%b s=%h, required busy=0 done=0 s=%h",
               idx, busy_v[idx], done_v[idx], get_s(idx), prev_s[idx]);
    end
  endtask

  task automatic check_all_cleared(input string tag);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || get_s(i) !== 16'h0000 ||
          cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s u%0d: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                 tag, i, busy_v[i], done_v[i], get_s(i), cout_v[i], ovf_v[i]);
      end
      prev_s[i] = 16'h0000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '1;
    a_in = 16'h1234; b_in = 16'h4321; cin_in = 1'b0; sub_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_cleared("reset_state");
    start_v = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_v !== 5'b0 || done_v !== 5'b0) begin
      failures++;
      $display("FAIL start_during_rst: busy=%b done=%b, required 00000 00000", busy_v, done_v);
    end
  endtask

  task automatic test_add();
    run_op(0, 16'h003C, 16'h005A, 1'b0, 1'b0, 1'b0);
    check_idle(0);
  endtask

  task automatic test_sub();
    run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b1, 1'b0);
    check_idle(0);
    run_op(0, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0);
    check_idle(0);
  endtask

  task automatic test_ignore_start();
    run_op(0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
    check_idle(0);
    run_op(4, 16'h1234, 16'h0FFF, 1'b1, 1'b1, 1'b1);
    check_idle(4);
  endtask

  task automatic test_mid_run_reset();
    bit saw_done;
    a_in = 16'h003C; b_in = 16'h005A; cin_in = 1'b0; sub_in = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_cleared("mid_run_reset");
    rst = 1'b0;
    saw_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abandoned_op: activity seen after reset, required busy=0 done=0");
    end
    run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    check_idle(0);
  endtask

  task automatic test_back_to_back();
    run_op(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(4, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
    check_idle(4);
  endtask

  task automatic test_full_digit();
    run_op(3, 16'h00C3, 16'h0071, 1'b1, 1'b0, 1'b0);
    check_idle(3);
    run_op(3, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    check_idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 30; j++) begin
        run_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               (n_t[i] > 1) && ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) check_idle(i);
      end
      check_idle(i);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    for (int i = 0; i < 5; i++) prev_s[i] = 16'h0000;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_mid_run_reset();
    test_back_to_back();
    test_full_digit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
